// File: rtl/uart_pkg.sv
// Shared UART constants: state encoding, baud divisors, frame geometry and helpers.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int CLK_HZ = 50_000_000;
  localparam int OVS    = 16;

  // Rounded clk cycles per oversample tick for each supported baud rate.
  localparam int DIV_9600 = (CLK_HZ + (9600 * OVS) / 2) / (9600 * OVS);
  localparam int DIV_2400 = (CLK_HZ + (2400 * OVS) / 2) / (2400 * OVS);

  // Tick counter width and the three mid-bit sample points (7th, 8th, 9th tick of a bit).
  localparam int               TICK_W        = $clog2(OVS);
  localparam logic [TICK_W-1:0] TICK_SAMPLE_A = TICK_W'(6);
  localparam logic [TICK_W-1:0] TICK_SAMPLE_B = TICK_W'(7);
  localparam logic [TICK_W-1:0] TICK_SAMPLE_C = TICK_W'(8);

  // Data bit counter end values and stop-bit counts, shared with the transmitter.
  localparam logic [2:0] BIT_END_7  = 3'd6;
  localparam logic [2:0] BIT_END_8  = 3'd7;
  localparam logic [1:0] STOP_CNT_1 = 2'd1;
  localparam logic [1:0] STOP_CNT_2 = 2'd2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Parallel character port of the receiver: received data plus status flags.
`timescale 1ns/1ps
interface uart_rx_if;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       pattern_err;
  logic       busy;

  modport master (
    output data,
    output data_valid,
    output frame_err,
    output pattern_err,
    output busy
  );

  modport slave (
    input data,
    input data_valid,
    input frame_err,
    input pattern_err,
    input busy
  );
endinterface

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-clk tick every DIV clocks, restartable for phase alignment.
`timescale 1ns/1ps
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int DIV_FAST = DIV_9600,
  parameter int DIV_SLOW = DIV_2400
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic sel,
  output logic tick
);

  localparam int DIV_MAX = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int CNT_W   = $clog2(DIV_MAX);

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_last;

  assign div_last = sel ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);
  assign tick     = (div_cnt == div_last) && !restart;

  // Divide-by-DIV counter; restart forces a fresh period so ticks line up with the start edge.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      div_cnt <= '0;
    end else if (div_cnt == div_last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, mid-bit majority sampler, deframing FSM and pattern checker.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIV_FAST = DIV_9600,
  parameter int DIV_SLOW = DIV_2400
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rxd,
  input  logic      sw4,
  input  logic      sw5,
  input  logic      sw8,
  uart_rx_if.master bus
);

  logic rxd_meta, rxd_sync, rxd_prev;
  logic start_edge, restart, tick;

  logic [TICK_W-1:0] tick_cnt;
  logic [1:0]        samp;
  logic              bit_eval, bit_val;

  rx_state_t  state;
  logic       cfg_8bit, cfg_2stop, cfg_fast;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [1:0] stop_cnt;
  logic       stop_err, deliver;
  logic       have_prev, prev_ones;
  logic [7:0] data_q;
  logic       data_valid_q, frame_err_q, pattern_err_q, busy_q;

  logic [2:0] bit_end;
  logic [1:0] stop_last;
  logic [7:0] rx_char;
  logic       char_zero, char_ones, char_valid, last_stop;

  assign start_edge = rxd_prev & ~rxd_sync;
  assign restart    = (state == ST_IDLE) && start_edge;

  assign bit_eval = tick && (tick_cnt == TICK_SAMPLE_C);
  assign bit_val  = majority3(samp[0], samp[1], rxd_sync);

  assign bit_end   = cfg_8bit ? BIT_END_8 : BIT_END_7;
  assign stop_last = cfg_2stop ? STOP_CNT_2 : STOP_CNT_1;
  assign last_stop = (stop_cnt + 2'd1) == stop_last;

  // In 7-bit mode the character sits in shift_reg[7:1] because bits enter at the MSB.
  assign rx_char    = cfg_8bit ? shift_reg : {1'b0, shift_reg[7:1]};
  assign char_zero  = (rx_char == 8'h00);
  assign char_ones  = (rx_char == (cfg_8bit ? 8'hFF : 8'h7F));
  assign char_valid = char_zero | char_ones;

  assign bus.data        = data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.pattern_err = pattern_err_q;
  assign bus.busy        = busy_q;

  uart_os_tick #(
    .DIV_FAST (DIV_FAST),
    .DIV_SLOW (DIV_SLOW)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .sel     (cfg_fast),
    .tick    (tick)
  );

  // Two-stage synchronizer plus one history stage for falling-edge detection; idle level is 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Per-bit tick counter and capture of the first two mid-bit samples; the third is live.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      tick_cnt <= '0;
      samp     <= 2'b00;
    end else if (tick) begin
      tick_cnt <= tick_cnt + TICK_W'(1);
      if (tick_cnt == TICK_SAMPLE_A) samp[0] <= rxd_sync;
      if (tick_cnt == TICK_SAMPLE_B) samp[1] <= rxd_sync;
    end
  end

  // Deframing FSM with registered outputs; delivery happens one clk after the last stop-bit vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cfg_8bit      <= 1'b0;
      cfg_2stop     <= 1'b0;
      cfg_fast      <= 1'b0;
      shift_reg     <= 8'h00;
      bit_cnt       <= 3'd0;
      stop_cnt      <= 2'd0;
      stop_err      <= 1'b0;
      deliver       <= 1'b0;
      have_prev     <= 1'b0;
      prev_ones     <= 1'b0;
      data_q        <= 8'h00;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      pattern_err_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            cfg_8bit  <= sw4;
            cfg_2stop <= sw5;
            cfg_fast  <= sw8;
            busy_q    <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_eval) begin
            if (bit_val) begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              bit_cnt <= 3'd0;
              state   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (bit_eval) begin
            shift_reg <= {bit_val, shift_reg[7:1]};
            if (bit_cnt == bit_end) begin
              stop_cnt <= 2'd0;
              stop_err <= 1'b0;
              deliver  <= 1'b0;
              state    <= ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (deliver) begin
            deliver      <= 1'b0;
            data_valid_q <= 1'b1;
            data_q       <= rx_char;
            frame_err_q  <= stop_err;
            // Only cleanly framed characters take part in the alternating-pattern check.
            if (!stop_err) begin
              if (!char_valid || (have_prev && (prev_ones == char_ones))) begin
                pattern_err_q <= 1'b1;
              end
              if (char_valid) begin
                have_prev <= 1'b1;
                prev_ones <= char_ones;
              end
            end
            if (rxd_sync) begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              state <= ST_BREAK;
            end
          end else if (bit_eval) begin
            if (!bit_val) stop_err <= 1'b1;
            if (last_stop) begin
              deliver <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 2'd1;
            end
          end
        end
        ST_BREAK: begin
          if (rxd_sync) begin
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx with shortened baud divisors to keep runs short.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int      DIV_FAST = 5;
  localparam int      DIV_SLOW = 20;
  localparam realtime CLK_NS   = 20.0;
  localparam realtime BIT_FAST = 16 * DIV_FAST * CLK_NS;
  localparam realtime BIT_SLOW = 16 * DIV_SLOW * CLK_NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic sw4 = 1'b1;
  logic sw5 = 1'b0;
  logic sw8 = 1'b1;

  uart_rx_if bus();

  uart_rx #(
    .DIV_FAST (DIV_FAST),
    .DIV_SLOW (DIV_SLOW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .sw4 (sw4),
    .sw5 (sw5),
    .sw8 (sw8),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int         dv_count = 0;
  logic [7:0] dv_data;
  logic       dv_fe, dv_pe;
  realtime    dv_time;
  realtime    tx_start_time;

  always #10 clk = ~clk;

  // Capture every data_valid pulse away from the active edge.
  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      dv_count = dv_count + 1;
      dv_data  = bus.data;
      dv_fe    = bus.frame_err;
      dv_pe    = bus.pattern_err;
      dv_time  = $realtime;
    end
  end

  // Guard against a hung run.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] value, input int nbits, input int nstop,
                            input logic stop_val, input realtime bit_ns);
    @(posedge clk);
    #2 rxd = 1'b0;
    tx_start_time = $realtime;
    #(bit_ns);
    for (int i = 0; i < nbits; i++) begin
      rxd = value[i];
      #(bit_ns);
    end
    for (int i = 0; i < nstop; i++) begin
      rxd = stop_val;
      #(bit_ns);
    end
    if (stop_val) #(bit_ns);
  endtask

  task automatic test_reset();
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    @(negedge clk);
    total++; if (bus.data !== 8'h00) begin bad++; $display("[TB] FAIL reset_data got=%h exp=00", bus.data); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_dv got=%b exp=0", bus.data_valid); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_fe got=%b exp=0", bus.frame_err); end
    total++; if (bus.pattern_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_pe got=%b exp=0", bus.pattern_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic_8n1();
    int base;
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    base = dv_count;
    send_frame(8'h00, 8, 1, 1'b1, BIT_FAST);
    total++; if (dv_data !== 8'h00) begin bad++; $display("[TB] FAIL basic_data0 got=%h exp=00", dv_data); end
    send_frame(8'hFF, 8, 1, 1'b1, BIT_FAST);
    total++; if (dv_data !== 8'hFF) begin bad++; $display("[TB] FAIL basic_data1 got=%h exp=ff", dv_data); end
    total++; if (dv_count - base !== 2) begin bad++; $display("[TB] FAIL basic_count got=%0d exp=2", dv_count - base); end
    total++; if (dv_fe !== 1'b0) begin bad++; $display("[TB] FAIL basic_fe got=%b exp=0", dv_fe); end
    total++; if (dv_pe !== 1'b0) begin bad++; $display("[TB] FAIL basic_pe got=%b exp=0", dv_pe); end
  endtask

  task automatic test_7n2_slow();
    int base;
    int lat;
    sw4 = 1'b0; sw5 = 1'b1; sw8 = 1'b0;
    do_reset();
    base = dv_count;
    send_frame(8'h7F, 7, 2, 1'b0, BIT_SLOW);
    rxd = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    lat = int'((dv_time - tx_start_time) / CLK_NS);
    total++; if (dv_count - base !== 1) begin bad++; $display("[TB] FAIL slow_count got=%0d exp=1", dv_count - base); end
    total++; if (dv_data !== 8'h7F) begin bad++; $display("[TB] FAIL slow_data got=%h exp=7f", dv_data); end
    total++; if (dv_fe !== 1'b1) begin bad++; $display("[TB] FAIL slow_fe got=%b exp=1", dv_fe); end
    total++;
    if (lat < 153 * DIV_SLOW + 2 || lat > 153 * DIV_SLOW + 6) begin
      bad++; $display("[TB] FAIL slow_latency got=%0d exp=%0d..%0d", lat, 153 * DIV_SLOW + 2, 153 * DIV_SLOW + 6);
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL slow_busy_after got=%b exp=0", bus.busy); end
  endtask

  task automatic test_glitch();
    int   base;
    logic went_low;
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    base = dv_count;
    @(posedge clk);
    #2 rxd = 1'b0;
    repeat (3 * DIV_FAST) @(posedge clk);
    #2 rxd = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_set got=%b exp=1", bus.busy); end
    went_low = 1'b0;
    for (int n = 0; n < 9 * DIV_FAST + 8 && !went_low; n++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) went_low = 1'b1;
    end
    total++; if (went_low !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_clear got=%b exp=1", went_low); end
    #(2 * BIT_FAST);
    total++; if (dv_count - base !== 0) begin bad++; $display("[TB] FAIL glitch_no_dv got=%0d exp=0", dv_count - base); end
  endtask

  task automatic test_break();
    int base;
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    base = dv_count;
    send_frame(8'h00, 8, 1, 1'b0, BIT_FAST);
    #(20 * BIT_FAST);
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL break_busy got=%b exp=1", bus.busy); end
    total++; if (dv_count - base !== 1) begin bad++; $display("[TB] FAIL break_count got=%0d exp=1", dv_count - base); end
    total++; if (dv_fe !== 1'b1) begin bad++; $display("[TB] FAIL break_fe got=%b exp=1", dv_fe); end
    rxd = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL break_release got=%b exp=0", bus.busy); end
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("[TB] FAIL break_fe_held got=%b exp=1", bus.frame_err); end
    #(BIT_FAST);
    send_frame(8'hFF, 8, 1, 1'b1, BIT_FAST);
    total++; if (dv_data !== 8'hFF) begin bad++; $display("[TB] FAIL break_next_data got=%h exp=ff", dv_data); end
    total++; if (dv_fe !== 1'b0) begin bad++; $display("[TB] FAIL break_next_fe got=%b exp=0", dv_fe); end
    total++; if (dv_pe !== 1'b0) begin bad++; $display("[TB] FAIL break_next_pe got=%b exp=0", dv_pe); end
  endtask

  task automatic test_pattern();
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    send_frame(8'h00, 8, 1, 1'b1, BIT_FAST);
    total++; if (dv_pe !== 1'b0) begin bad++; $display("[TB] FAIL pat_first got=%b exp=0", dv_pe); end
    send_frame(8'h00, 8, 1, 1'b1, BIT_FAST);
    total++; if (dv_pe !== 1'b1) begin bad++; $display("[TB] FAIL pat_repeat got=%b exp=1", dv_pe); end
    send_frame(8'h5A, 8, 1, 1'b1, BIT_FAST);
    total++; if (dv_data !== 8'h5A) begin bad++; $display("[TB] FAIL pat_5a_data got=%h exp=5a", dv_data); end
    total++; if (bus.pattern_err !== 1'b1) begin bad++; $display("[TB] FAIL pat_sticky got=%b exp=1", bus.pattern_err); end
  endtask

  task automatic test_reset_midframe();
    int base;
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    send_frame(8'hFF, 8, 1, 1'b1, BIT_FAST);
    send_frame(8'hFF, 8, 1, 1'b1, BIT_FAST);
    total++; if (bus.pattern_err !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_pe got=%b exp=1", bus.pattern_err); end
    base = dv_count;
    @(posedge clk);
    #2 rxd = 1'b0;
    #(BIT_FAST);
    rxd = 1'b1;
    #(4 * BIT_FAST + BIT_FAST / 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.data !== 8'h00) begin bad++; $display("[TB] FAIL mid_data got=%h exp=00", bus.data); end
    total++; if (bus.pattern_err !== 1'b0) begin bad++; $display("[TB] FAIL mid_pe got=%b exp=0", bus.pattern_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b exp=0", bus.busy); end
    total++; if (bus.data_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_dv got=%b exp=0", bus.data_valid); end
    rst = 1'b0;
    #(10 * BIT_FAST);
    total++; if (dv_count - base !== 0) begin bad++; $display("[TB] FAIL mid_no_dv got=%0d exp=0", dv_count - base); end
    send_frame(8'hFF, 8, 1, 1'b1, BIT_FAST);
    total++; if (dv_data !== 8'hFF) begin bad++; $display("[TB] FAIL mid_next_data got=%h exp=ff", dv_data); end
    total++; if (dv_pe !== 1'b0) begin bad++; $display("[TB] FAIL mid_next_pe got=%b exp=0", dv_pe); end
  endtask

  task automatic test_sw4_toggle();
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    fork
      send_frame(8'hFF, 8, 1, 1'b1, BIT_FAST);
      begin #(4 * BIT_FAST); sw4 = 1'b0; end
    join
    total++; if (dv_data !== 8'hFF) begin bad++; $display("[TB] FAIL tog_8bit_data got=%h exp=ff", dv_data); end
    sw4 = 1'b0;
    fork
      send_frame(8'h00, 7, 1, 1'b1, BIT_FAST);
      begin #(4 * BIT_FAST); sw4 = 1'b1; end
    join
    total++; if (dv_data !== 8'h00) begin bad++; $display("[TB] FAIL tog_7bit_data got=%h exp=00", dv_data); end
    total++; if (dv_fe !== 1'b0) begin bad++; $display("[TB] FAIL tog_7bit_fe got=%b exp=0", dv_fe); end
    sw4 = 1'b0;
    send_frame(8'h7F, 7, 1, 1'b1, BIT_FAST);
    total++; if (dv_data !== 8'h7F) begin bad++; $display("[TB] FAIL tog_7f_data got=%h exp=7f", dv_data); end
    total++; if (dv_pe !== 1'b0) begin bad++; $display("[TB] FAIL tog_7f_pe got=%b exp=0", dv_pe); end
  endtask

  task automatic test_skew();
    logic [7:0] vals [4];
    realtime    bits [4];
    vals = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    bits = '{BIT_FAST * 1.02, BIT_FAST * 0.98, BIT_FAST * 0.98, BIT_FAST * 1.02};
    sw4 = 1'b1; sw5 = 1'b0; sw8 = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(vals[i], 8, 1, 1'b1, bits[i]);
      total++; if (dv_data !== vals[i]) begin bad++; $display("[TB] FAIL skew_data%0d got=%h exp=%h", i, dv_data, vals[i]); end
      total++; if (dv_fe !== 1'b0) begin bad++; $display("[TB] FAIL skew_fe%0d got=%b exp=0", i, dv_fe); end
    end
    total++; if (dv_pe !== 1'b0) begin bad++; $display("[TB] FAIL skew_pe got=%b exp=0", dv_pe); end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] uart_rx directed tests start");
    test_reset();
    test_basic_8n1();
    test_7n2_slow();
    test_glitch();
    test_break();
    test_pattern();
    test_reset_midframe();
    test_sw4_toggle();
    test_skew();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
